multiply_divide_unit: RTL and testbench

Sequential HI/LO unit beside the execute-stage ALU. Accepts MUL/MULU/DIV/DIVU from the execute stage and owns the architectural hi/lo registers; the ALU returns these registers for MFHI/MFLO. Multiply completes in one cycle; divide is an iterative restoring divider of DATA_WIDTH steps. During a divide, busy stalls the pipeline so that MFHI/MFLO never reads a stale value.

---
 rtl/multiply_divide_unit.sv | 165 ++++++++++++++++
 tb/tb_multiply_divide_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multiply_divide_unit.sv
// HI/LO unit: single-cycle signed/unsigned multiply and a DATA_WIDTH-step
// restoring divider with sign fix-up, flush and async reset.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL  6'h18
`endif
`ifndef ALU_OP_MULU
`define ALU_OP_MULU 6'h19
`endif
`ifndef ALU_OP_DIV
`define ALU_OP_DIV  6'h1A
`endif
`ifndef ALU_OP_DIVU
`define ALU_OP_DIVU 6'h1B
`endif

module multiply_divide_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [`ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]    rs,
  input  logic [DATA_WIDTH-1:0]    rt,
  output logic [DATA_WIDTH-1:0]    hi,
  output logic [DATA_WIDTH-1:0]    lo,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic           done_q, done_d;

  logic           accept, is_mul, is_mulu, is_div, is_divu, sgn_div;
  logic [2*W-1:0] prod_s, prod_u;
  logic [W-1:0]   rs_mag, rt_mag;
  logic [W:0]     rem_sh, dvs_ext, diff;
  logic           no_borrow;

  always_comb begin
    is_mul  = (op == `ALU_OP_MUL);
    is_mulu = (op == `ALU_OP_MULU);
    is_div  = (op == `ALU_OP_DIV);
    is_divu = (op == `ALU_OP_DIVU);
    sgn_div = is_div;
    accept  = en && !stall && !flush && (state_q == S_IDLE);

    prod_s = $signed({{W{rs[W-1]}}, rs}) * $signed({{W{rt[W-1]}}, rt});
    prod_u = {{W{1'b0}}, rs} * {{W{1'b0}}, rt};

    rs_mag = (sgn_div && rs[W-1]) ? ('0 - rs) : rs;
    rt_mag = (sgn_div && rt[W-1]) ? ('0 - rt) : rt;

    // Restoring step: the shifted remainder needs one extra bit before compare.
    rem_sh    = {rem_q, quo_q[W-1]};
    dvs_ext   = {1'b0, dvs_q};
    no_borrow = (rem_sh >= dvs_ext);
    diff      = rem_sh - dvs_ext;
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && (is_mul || is_mulu)) begin
          {hi_d, lo_d} = is_mul ? prod_s : prod_u;
          done_d       = 1'b1;
        end else if (accept && (is_div || is_divu)) begin
          quo_d   = rs_mag;
          dvs_d   = rt_mag;
          qneg_d  = sgn_div && (rs[W-1] ^ rt[W-1]);
          rneg_d  = sgn_div && rs[W-1];
          dz_d    = (rt == '0);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = no_borrow ? diff[W-1:0] : rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], no_borrow};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          // Divide-by-zero quotient is forced to all ones; the remainder
          // fix-up alone already reproduces the raw dividend.
          lo_d   = dz_q ? '1 : (qneg_q ? ('0 - quo_q) : quo_q);
          hi_d   = rneg_q ? ('0 - rem_q) : rem_q;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Self-checking bench for multiply_divide_unit: directed test-plan cases plus
// randomized ops against an arithmetic reference model.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL  6'h18
`endif
`ifndef ALU_OP_MULU
`define ALU_OP_MULU 6'h19
`endif
`ifndef ALU_OP_DIV
`define ALU_OP_DIV  6'h1A
`endif
`ifndef ALU_OP_DIVU
`define ALU_OP_DIVU 6'h1B
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  6'h20
`endif

module tb_multiply_divide_unit;

  logic                     clk = 1'b0;
  logic                     rst, en, stall, flush;
  logic [`ALU_OP_WIDTH-1:0] op;
  logic [31:0]              rs, rt, hi, lo;
  logic                     busy, done;

  int checks   = 0;
  int failures = 0;

  multiply_divide_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush), .op(op),
    .rs(rs), .rt(rt), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: {hi,lo} from plain 64-bit arithmetic on the operand values.
  function automatic logic [63:0] model(input logic [5:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      `ALU_OP_MUL:  res = sa * sb;
      `ALU_OP_MULU: res = {32'b0, a} * {32'b0, b};
      `ALU_OP_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      `ALU_OP_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit stall_in, input bit poke_mul);
    logic [63:0] exp;
    int cyc;
    exp = model(o, a, b);
    @(negedge clk);
    en = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    en = 1'b0;
    if (o == `ALU_OP_MUL || o == `ALU_OP_MULU) begin
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    end else begin
      stall = stall_in;
      if (poke_mul) begin
        en = 1'b1; op = `ALU_OP_MUL; rs = $urandom; rt = $urandom;
      end
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
        cyc++;
        @(negedge clk);
      end
      en = 1'b0; stall = 1'b0;
      check({tag, "_busy_cycles"}, cyc, 32'd33);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
    end
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
  endtask

  initial begin
    logic [5:0]  ops [4];
    logic [5:0]  o;
    logic [31:0] a, b;
    int          cyc;
    ops[0] = `ALU_OP_MUL; ops[1] = `ALU_OP_MULU; ops[2] = `ALU_OP_DIV; ops[3] = `ALU_OP_DIVU;

    rst = 1'b1; en = 1'b0; stall = 1'b0; flush = 1'b0;
    op = '0; rs = '0; rt = '0;
    #22 rst = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);

    @(negedge clk);
    en = 1'b1; op = `ALU_OP_ADD; rs = 32'd9; rt = 32'd5;
    @(negedge clk);
    en = 1'b0;
    check("add_ignored_hi", hi, 32'd0);
    check("add_ignored_lo", lo, 32'd0);
    check("add_ignored_done", {31'b0, done}, 32'd0);

    run_op("mul_neg1x2", `ALU_OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_op("mulu_max_x2", `ALU_OP_MULU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_op("div_m7_2", `ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("divu_100_7", `ALU_OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("div_ovf", `ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_5_0", `ALU_OP_DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("div_m9_0", `ALU_OP_DIV, 32'hFFFF_FFF7, 32'd0, 1'b0, 1'b0);
    run_op("div_stall", `ALU_OP_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b0);
    run_op("div_poke_mul", `ALU_OP_DIVU, 32'hDEAD_BEEF, 32'd13, 1'b0, 1'b1);

    // Flush blocks an accept in IDLE.
    run_op("mul_3x4", `ALU_OP_MUL, 32'd3, 32'd4, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b1; flush = 1'b1; op = `ALU_OP_MUL; rs = 32'd7; rt = 32'd7;
    @(negedge clk);
    en = 1'b0; flush = 1'b0;
    check("flush_idle_done", {31'b0, done}, 32'd0);
    check("flush_idle_lo", lo, 32'd12);

    // Flush mid-divide keeps the pre-divide hi/lo and emits no done.
    @(negedge clk);
    en = 1'b1; op = `ALU_OP_DIVU; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_hi", hi, 32'd0);
    check("flush_lo", lo, 32'd12);
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) cyc++;
    end
    check("flush_no_late_done", cyc, 32'd0);
    run_op("div_after_flush", `ALU_OP_DIV, 32'hFFFF_F000, 32'd77, 1'b0, 1'b0);

    // Async reset between clock edges mid-divide.
    @(negedge clk);
    en = 1'b1; op = `ALU_OP_DIVU; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    en = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    #1 rst = 1'b0;
    run_op("mul_after_rst", `ALU_OP_MUL, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      o = ops[$urandom_range(3, 0)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7, 0))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(15, 1);
        3: b = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), o, a, b, 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
